// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and data access (D).
// Optional starvation guard for fetch enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
`ifdef ARB_STARVE_GUARD_EN
  , parameter int MAX_D_GRANTS = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e            state_q;
  logic              m_req_q, m_we_q, if_valid_q, d_valid_q, drop_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q, d_rdata_q;
  logic [31:0]       if_rdata_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_D_GRANTS + 1);
  logic [CW-1:0] cnt_q;
  // Fetch wins once D has taken MAX_D_GRANTS back-to-back grants against a waiting fetch.
  wire force_i = (cnt_q == CW'(MAX_D_GRANTS)) & d_req & if_req & ~flush;
`else
  wire force_i = 1'b0;
`endif

  wire grant_d = d_req & ~force_i;
  wire grant_i = ~grant_d & if_req & ~flush;
  wire [31:0] fetch_word = m_addr_q[2] ? m_rdata[DATA_W-1 -: 32] : m_rdata[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      drop_q     <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      cnt_q      <= '0;
`endif
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q   <= BUSY_D;
            m_req_q   <= 1'b1;
            m_we_q    <= d_we;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
`ifdef ARB_STARVE_GUARD_EN
            if (!if_req)                         cnt_q <= '0;
            else if (cnt_q != CW'(MAX_D_GRANTS)) cnt_q <= cnt_q + 1'b1;
`endif
          end else if (grant_i) begin
            state_q  <= BUSY_I;
            m_req_q  <= 1'b1;
            m_we_q   <= 1'b0;
            m_addr_q <= if_addr;
            drop_q   <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            cnt_q    <= '0;
`endif
          end
        end
        BUSY_I: begin
          if (m_ack) begin
            state_q <= IDLE;
            m_req_q <= 1'b0;
            drop_q  <= 1'b0;
            // A flush landing on the ack cycle still discards the fetch.
            if (!(drop_q || flush)) begin
              if_rdata_q <= fetch_word;
              if_valid_q <= 1'b1;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        BUSY_D: begin
          if (m_ack) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            d_valid_q <= 1'b1;
            if (!m_we_q) d_rdata_q <= m_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign if_valid = if_valid_q;
  assign d_rdata  = d_rdata_q;
  assign d_valid  = d_valid_q;
  // Stalls are masked in reset so every output reads 0 while rst_n is low.
  assign d_stall  = rst_n & d_req & ~d_valid_q;
  assign if_stall = (rst_n & if_req & ~if_valid_q) | d_stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: reset, fetch, contention, store, flush, guard.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req = 0, flush = 0, d_req = 0, d_we = 0, m_ack = 0;
  logic [63:0] if_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall, d_valid, d_stall, m_req, m_we;
  logic [63:0] d_rdata, m_addr, m_wdata;
  int chk = 0, pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64)
`ifdef ARB_STARVE_GUARD_EN
    , .MAX_D_GRANTS(2)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall), .flush(flush), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .d_stall(d_stall), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    #1;
    outs = {if_valid, if_stall, d_valid, d_stall, m_req, m_we, |if_rdata, |d_rdata};
    chk++; if (outs !== 8'h00) $display("FAIL reset_outs: got %h want 00", outs); else pass++;
    cyc(); rst_n = 1;
    d_req = 1; d_addr = 64'h8; cyc();
    chk++; if (m_req !== 1'b1) $display("FAIL rst_busy_d: m_req %b want 1", m_req); else pass++;
    cyc();
    rst_n = 0; m_ack = 1; m_rdata = 64'h55; #1;
    outs = {if_valid, if_stall, d_valid, d_stall, m_req, m_we, |m_addr, |d_rdata};
    chk++; if (outs !== 8'h00) $display("FAIL rst_mid_busy: got %h want 00", outs); else pass++;
    cyc();
    chk++; if (d_valid !== 1'b0) $display("FAIL rst_no_valid: d_valid %b want 0", d_valid); else pass++;
    rst_n = 1; d_req = 0; m_ack = 0;
    if_req = 1; if_addr = 64'h0; cyc();
    chk++; if (m_req !== 1'b1 || m_we !== 1'b0) $display("FAIL rst_if_grant: m_req %b m_we %b want 1 0", m_req, m_we); else pass++;
    m_ack = 1; m_rdata = 64'h0; cyc();
    m_ack = 0; if_req = 0; cyc();
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 64'h104; cyc();
    chk++; if (m_req !== 1'b1 || m_addr !== 64'h104) $display("FAIL fetch_req: m_req %b m_addr %h want 1 104", m_req, m_addr); else pass++;
    chk++; if (if_stall !== 1'b1) $display("FAIL fetch_stall: if_stall %b want 1", if_stall); else pass++;
    cyc(); cyc(); cyc();
    m_ack = 1; m_rdata = 64'hAAAA_BBBB_1111_2222; cyc();
    chk++; if (if_valid !== 1'b1 || if_rdata !== 32'hAAAABBBB) $display("FAIL fetch_data: valid %b data %h want 1 aaaabbbb", if_valid, if_rdata); else pass++;
    chk++; if (if_stall !== 1'b0 || m_req !== 1'b0) $display("FAIL fetch_done: stall %b m_req %b want 0 0", if_stall, m_req); else pass++;
    m_ack = 0; if_req = 0; cyc();
    chk++; if (if_valid !== 1'b0) $display("FAIL fetch_pulse: if_valid %b want 0", if_valid); else pass++;
  endtask

  task automatic test_contention();
    if_req = 1; if_addr = 64'h200; d_req = 1; d_we = 0; d_addr = 64'h40; cyc();
    chk++; if (m_addr !== 64'h40 || m_we !== 1'b0) $display("FAIL cont_d_first: m_addr %h m_we %b want 40 0", m_addr, m_we); else pass++;
    chk++; if (if_stall !== 1'b1 || d_stall !== 1'b1) $display("FAIL cont_stalls: if %b d %b want 1 1", if_stall, d_stall); else pass++;
    m_ack = 1; m_rdata = 64'h1122_3344_5566_7788; cyc();
    chk++; if (d_valid !== 1'b1 || d_rdata !== 64'h1122_3344_5566_7788) $display("FAIL cont_d_data: valid %b data %h want 1 1122334455667788", d_valid, d_rdata); else pass++;
    chk++; if (if_stall !== 1'b1) $display("FAIL cont_if_stall: if_stall %b want 1", if_stall); else pass++;
    m_ack = 0; d_req = 0; cyc();
    chk++; if (m_req !== 1'b1 || m_addr !== 64'h200 || if_stall !== 1'b1) $display("FAIL cont_i_grant: m_req %b m_addr %h stall %b want 1 200 1", m_req, m_addr, if_stall); else pass++;
    m_ack = 1; m_rdata = 64'hCAFE_F00D_DEAD_BEEF; cyc();
    chk++; if (if_valid !== 1'b1 || if_rdata !== 32'hDEADBEEF) $display("FAIL cont_i_data: valid %b data %h want 1 deadbeef", if_valid, if_rdata); else pass++;
    m_ack = 0; if_req = 0; cyc();
  endtask

  task automatic test_store();
    d_req = 1; d_we = 1; d_addr = 64'h10; d_wdata = 64'h5; cyc();
    chk++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_wdata !== 64'h5 || m_addr !== 64'h10) $display("FAIL store_bus: req %b we %b wdata %h addr %h want 1 1 5 10", m_req, m_we, m_wdata, m_addr); else pass++;
    m_ack = 1; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF; cyc();
    chk++; if (d_valid !== 1'b1 || d_rdata !== 64'h1122_3344_5566_7788) $display("FAIL store_done: valid %b rdata %h want 1 1122334455667788", d_valid, d_rdata); else pass++;
    m_ack = 0; d_req = 0; d_we = 0; cyc();
    chk++; if (d_valid !== 1'b0 || m_req !== 1'b0) $display("FAIL store_pulse: valid %b m_req %b want 0 0", d_valid, m_req); else pass++;
  endtask

  task automatic test_flush();
    if_req = 1; if_addr = 64'h300; cyc();
    flush = 1; cyc();
    flush = 0; cyc();
    m_ack = 1; m_rdata = 64'h1; cyc();
    chk++; if (if_valid !== 1'b0 || if_rdata !== 32'hDEADBEEF || m_req !== 1'b0) $display("FAIL flush_drop: valid %b data %h m_req %b want 0 deadbeef 0", if_valid, if_rdata, m_req); else pass++;
    m_ack = 0; if_addr = 64'h304; cyc();
    chk++; if (m_req !== 1'b1 || m_addr !== 64'h304) $display("FAIL flush_next: m_req %b m_addr %h want 1 304", m_req, m_addr); else pass++;
    m_ack = 1; m_rdata = 64'h9999_8888_7777_6666; cyc();
    chk++; if (if_valid !== 1'b1 || if_rdata !== 32'h99998888) $display("FAIL flush_next_data: valid %b data %h want 1 99998888", if_valid, if_rdata); else pass++;
    m_ack = 0; if_addr = 64'h308; cyc();
    m_ack = 1; flush = 1; m_rdata = 64'h2; cyc();
    chk++; if (if_valid !== 1'b0 || if_rdata !== 32'h99998888) $display("FAIL flush_on_ack: valid %b data %h want 0 99998888", if_valid, if_rdata); else pass++;
    m_ack = 0; flush = 1; if_addr = 64'h30C; cyc();
    chk++; if (m_req !== 1'b0) $display("FAIL flush_idle_block: m_req %b want 0", m_req); else pass++;
    flush = 0; cyc();
    chk++; if (m_req !== 1'b1 || m_addr !== 64'h30C) $display("FAIL flush_idle_resume: m_req %b m_addr %h want 1 30c", m_req, m_addr); else pass++;
    m_ack = 1; m_rdata = 64'h0; cyc();
    m_ack = 0; if_req = 0; cyc();
  endtask

  task automatic test_guard();
    logic exp_i, got_i;
    d_req = 1; d_we = 0; d_addr = 64'h80; if_req = 1; if_addr = 64'h400;
    for (int g = 0; g < 6; g++) begin
      cyc();
`ifdef ARB_STARVE_GUARD_EN
      exp_i = (g % 3) == 2;
`else
      exp_i = 1'b0;
`endif
      got_i = (m_addr == 64'h400);
      chk++; if (m_req !== 1'b1 || got_i !== exp_i) $display("FAIL guard_grant%0d: m_req %b I-grant %b want 1 %b", g, m_req, got_i, exp_i); else pass++;
      m_ack = 1; m_rdata = 64'h0; cyc();
      m_ack = 0;
    end
    d_req = 0; if_req = 0; cyc(); cyc();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_flush();
    test_guard();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
